// File: rtl/emulador_hcsr04.sv
// HC-SR04 ultrasonic sensor emulator, responder side of the trigger/echo protocol.
// Validates the trigger pulse width and waits the burst delay. It then drives an echo
// pulse of distancia * R clocks, or TIMEOUT clocks for an out-of-range distance, and
// ignores triggers for HOLDOFF clocks after the echo ends.
//
// Ports:
//   clock         - system clock, rising edge
//   reset         - asynchronous, active-low
//   trigger       - trigger from the sensor interface (synchronous to clock)
//   distancia     - emulated distance in cm
//   echo          - emulated echo pulse (registered)
//   ocupado       - high whenever the emulator is not idle
//   pronto        - one-cycle pulse on the cycle after echo falls (registered)
//   trigger_curto - one-cycle pulse when a too-short trigger is rejected (registered)
//   db_estado     - current state code for debug
module emulador_hcsr04 #(
  parameter int unsigned TRIG_MIN = 500,
  parameter int unsigned DELAY    = 10000,
  parameter int unsigned R        = 2941,
  parameter int unsigned MAX_CM   = 400,
  parameter int unsigned TIMEOUT  = 1900000,
  parameter int unsigned HOLDOFF  = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       ocupado,
  output logic       pronto,
  output logic       trigger_curto,
  output logic [2:0] db_estado
);

  localparam int unsigned CW = 21;
  localparam int unsigned TW = $clog2(TRIG_MIN + 1);

  localparam logic [2:0] OCIOSO       = 3'd0;
  localparam logic [2:0] MEDE_TRIGGER = 3'd1;
  localparam logic [2:0] ESPERA       = 3'd2;
  localparam logic [2:0] ECO          = 3'd3;
  localparam logic [2:0] PAUSA        = 3'd4;

  logic [2:0]    estado_q, estado_d;
  logic [TW-1:0] larg_q, larg_d;    // trigger width, saturating at TRIG_MIN
  logic [CW-1:0] cnt_q, cnt_d;      // delay / timeout / holdoff counter
  logic [CW-1:0] tick_q, tick_d;    // clocks within the current centimetre
  logic [8:0]    cm_q, cm_d;        // centimetres already emitted
  logic [8:0]    dist_q, dist_d;
  logic          echo_q, echo_d;
  logic          pronto_q, pronto_d;
  logic          curto_q, curto_d;

  logic          fora_faixa;
  logic          fim_eco;

  assign fora_faixa = (dist_q == 9'd0) || (32'(dist_q) > MAX_CM);

  // End-of-pulse detection: either the timeout counter or the nested tick/cm counters.
  always_comb begin
    fim_eco = 1'b0;
    if (fora_faixa) begin
      fim_eco = (cnt_q == CW'(TIMEOUT - 1));
    end else begin
      fim_eco = (tick_q == CW'(R - 1)) && (cm_q == dist_q - 9'd1);
    end
  end

  always_comb begin
    estado_d = estado_q;
    larg_d   = larg_q;
    cnt_d    = cnt_q;
    tick_d   = tick_q;
    cm_d     = cm_q;
    dist_d   = dist_q;
    echo_d   = 1'b0;
    pronto_d = 1'b0;
    curto_d  = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (trigger) begin
          estado_d = MEDE_TRIGGER;
          larg_d   = TW'(1);
        end
      end

      MEDE_TRIGGER: begin
        if (trigger) begin
          if (larg_q < TW'(TRIG_MIN)) begin
            larg_d = larg_q + TW'(1);
          end
        end else if (larg_q >= TW'(TRIG_MIN)) begin
          dist_d   = distancia;
          cnt_d    = '0;
          larg_d   = '0;
          estado_d = ESPERA;
        end else begin
          curto_d  = 1'b1;
          larg_d   = '0;
          estado_d = OCIOSO;
        end
      end

      ESPERA: begin
        if (cnt_q == CW'(DELAY - 1)) begin
          cnt_d    = '0;
          tick_d   = '0;
          cm_d     = '0;
          echo_d   = 1'b1;
          estado_d = ECO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ECO: begin
        if (fim_eco) begin
          cnt_d    = '0;
          tick_d   = '0;
          cm_d     = '0;
          pronto_d = 1'b1;
          estado_d = PAUSA;
        end else begin
          echo_d = 1'b1;
          if (fora_faixa) begin
            cnt_d = cnt_q + CW'(1);
          end else if (tick_q == CW'(R - 1)) begin
            tick_d = '0;
            cm_d   = cm_q + 9'd1;
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
      end

      PAUSA: begin
        if (cnt_q == CW'(HOLDOFF - 1)) begin
          cnt_d    = '0;
          estado_d = OCIOSO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        estado_d = OCIOSO;
        larg_d   = '0;
        cnt_d    = '0;
        tick_d   = '0;
        cm_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      larg_q   <= '0;
      cnt_q    <= '0;
      tick_q   <= '0;
      cm_q     <= '0;
      dist_q   <= '0;
      echo_q   <= 1'b0;
      pronto_q <= 1'b0;
      curto_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      larg_q   <= larg_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      cm_q     <= cm_d;
      dist_q   <= dist_d;
      echo_q   <= echo_d;
      pronto_q <= pronto_d;
      curto_q  <= curto_d;
    end
  end

  assign echo          = echo_q;
  assign pronto        = pronto_q;
  assign trigger_curto = curto_q;
  assign ocupado       = (estado_q != OCIOSO);
  assign db_estado     = estado_q;

endmodule

// File: tb/tb_emulador_hcsr04.sv
// Scoreboard bench for emulador_hcsr04: stimulus pushes expected events, a monitor
// pops and compares them whenever echo falls or trigger_curto pulses.
module tb_emulador_hcsr04;

  localparam int TRIG_MIN = 5;
  localparam int DELAY    = 20;
  localparam int R        = 10;
  localparam int MAX_CM   = 400;
  localparam int TIMEOUT  = 100;
  localparam int HOLDOFF  = 30;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic [8:0] distancia = '0;
  logic       echo, ocupado, pronto, trigger_curto;
  logic [2:0] db_estado;

  emulador_hcsr04 #(
    .TRIG_MIN(TRIG_MIN), .DELAY(DELAY), .R(R), .MAX_CM(MAX_CM),
    .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)
  ) dut (
    .clock(clock), .reset(reset), .trigger(trigger), .distancia(distancia),
    .echo(echo), .ocupado(ocupado), .pronto(pronto), .trigger_curto(trigger_curto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;  // number of rising edges seen
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0: echo pulse, 1: rejected trigger
    int tf;     // edge that first sampled trigger low
    int width;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int model_width(input int d);
    if (d == 0 || d > MAX_CM) return TIMEOUT;
    return d * R;
  endfunction

  // Raise trigger for n sampled cycles from idle and record the expected outcome.
  task automatic issue(input int d, input int n);
    exp_t e;
    @(negedge clock);
    distancia = 9'(d);
    trigger = 1'b1;
    repeat (n) @(negedge clock);
    trigger = 1'b0;
    e.tf = cyc + 1;
    e.kind = (n >= TRIG_MIN) ? 0 : 1;
    e.width = model_width(d);
    sb.push_back(e);
    @(negedge clock);
    // The latched value must survive later changes on distancia.
    distancia = 9'($urandom);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(ocupado == 1'b0 && sb.size() == 0) && k < 20000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 20000) chk("idle_timeout", 0, 1);
    repeat (2) @(negedge clock);
  endtask

  task automatic pulse_trig(input int n);
    trigger = 1'b1;
    repeat (n) @(negedge clock);
    trigger = 1'b0;
  endtask

  // Monitor
  initial begin
    int   rise_cyc;
    int   fall_cyc;
    bit   echo_prev;
    exp_t e;
    rise_cyc = -1;
    fall_cyc = -1;
    echo_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        rise_cyc = -1;
        fall_cyc = -1;
        echo_prev = 1'b0;
      end else begin
        if (echo && !echo_prev) rise_cyc = cyc;
        if (!echo && echo_prev) begin
          if (sb.size() == 0) begin
            chk("echo_unexpected", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("echo_kind", 0, e.kind);
            chk("echo_rise_delay", rise_cyc - e.tf, DELAY);
            chk("echo_width", cyc - rise_cyc, e.width);
          end
          chk("pronto_after_fall", int'(pronto), 1);
          fall_cyc = cyc;
        end else if (pronto) begin
          chk("pronto_stray", 1, 0);
        end
        if (fall_cyc >= 0 && cyc == fall_cyc + HOLDOFF - 1) chk("ocupado_holdoff", int'(ocupado), 1);
        if (fall_cyc >= 0 && cyc == fall_cyc + HOLDOFF) begin
          chk("ocupado_release", int'(ocupado), 0);
          fall_cyc = -1;
        end
        if (trigger_curto) begin
          if (sb.size() == 0) begin
            chk("curto_unexpected", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("curto_kind", 1, e.kind);
            chk("curto_time", cyc, e.tf);
            chk("curto_estado", int'(db_estado), 0);
          end
        end
        echo_prev = echo;
      end
    end
  end

  initial begin
    int d;
    int n;
    #1 reset = 1'b0;
    #1;
    chk("rst_echo", int'(echo), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_curto", int'(trigger_curto), 0);
    chk("rst_estado", int'(db_estado), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Normal measurement
    issue(37, 6);
    wait_idle();
    // Exactly TRIG_MIN accepted, one less rejected
    issue(3, TRIG_MIN);
    wait_idle();
    issue(3, TRIG_MIN - 1);
    wait_idle();
    chk("short_estado", int'(db_estado), 0);
    // Out-of-range and upper boundary
    issue(0, 6);
    wait_idle();
    issue(401, 6);
    wait_idle();
    issue(400, 6);
    wait_idle();
    issue(1, 6);
    wait_idle();

    // Triggers during ESPERA, ECO and PAUSA are ignored
    issue(20, 6);
    pulse_trig(3);
    repeat (DELAY) @(negedge clock);
    chk("busy_echo_high", int'(echo), 1);
    pulse_trig(7);
    distancia = 9'd5;
    n = 0;
    while (echo && n < 1000) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    chk("busy_pausa_state", int'(db_estado), 4);
    pulse_trig(7);
    wait_idle();

    // Reset mid-echo
    issue(50, 6);
    repeat (DELAY + 10) @(negedge clock);
    chk("pre_reset_echo", int'(echo), 1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("reset_drops_echo", int'(echo), 0);
    chk("reset_estado", int'(db_estado), 0);
    chk("reset_ocupado", int'(ocupado), 0);
    sb.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("after_reset_estado", int'(db_estado), 0);
    issue(12, 6);
    wait_idle();

    // Randomised measurements
    for (int i = 0; i < 14; i++) begin
      n = $urandom_range(3, 8);
      case ($urandom_range(0, 9))
        0: d = 0;
        1: d = $urandom_range(401, 511);
        default: d = $urandom_range(1, 60);
      endcase
      issue(d, n);
      wait_idle();
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
